// File: rtl/uart_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_if
//   Bundles the two word-requester ports, the UART transmitter handshake and
//   the scheduler status outputs into one interface.
//
//   Request ports (per port N = 0, 1):
//     reqN_valid   requester has a word
//     reqN_data    DATA_WIDTH-bit word
//     reqN_nbytes  byte count minus one (0 -> 1 byte ... 3 -> 4 bytes)
//     reqN_ready   accept strobe (word taken when high together with valid)
//   Transmitter side:
//     tx_data      byte for the transmitter buffer
//     tx_load      store tx_data into the transmitter buffer
//     tx_start     one-cycle start-transmission pulse
//     tx_done      transmitter done flag (level, held until cleared)
//     tx_flag_clr  one-cycle clear of tx_done
//   Status:
//     busy, grant_id, word_done, tx_error
//
//   Modports: slave  = the scheduler itself
//             master = the environment (requesters and transmitter)
// -----------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int UART_Nbit  = 8
);
  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic [1:0]            req0_nbytes;
  logic                  req0_ready;

  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic [1:0]            req1_nbytes;
  logic                  req1_ready;

  logic [UART_Nbit-1:0]  tx_data;
  logic                  tx_load;
  logic                  tx_start;
  logic                  tx_done;
  logic                  tx_flag_clr;

  logic                  busy;
  logic                  grant_id;
  logic                  word_done;
  logic                  tx_error;

  modport slave (
    input  req0_valid, req0_data, req0_nbytes,
    input  req1_valid, req1_data, req1_nbytes,
    input  tx_done,
    output req0_ready, req1_ready,
    output tx_data, tx_load, tx_start, tx_flag_clr,
    output busy, grant_id, word_done, tx_error
  );

  modport master (
    output req0_valid, req0_data, req0_nbytes,
    output req1_valid, req1_data, req1_nbytes,
    output tx_done,
    input  req0_ready, req1_ready,
    input  tx_data, tx_load, tx_start, tx_flag_clr,
    input  busy, grant_id, word_done, tx_error
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//   Shares one UART byte transmitter between two word requesters
//   (port 0: CPU store path, port 1: debug/trace path). Words are granted
//   round-robin, serialised LSB byte first into 1..4 bytes, and each byte is
//   driven through the transmitter's load / start / done / flag-clear
//   handshake. GAP_CYCLES idle cycles separate the bytes of one word.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    uart_tx_scheduler_if.slave (requests, transmitter, status)
//
//   Optional feature (macro UART_TX_TIMEOUT_EN):
//     defined   - a 13-bit watchdog limits the wait for tx_done to
//                 TIMEOUT_CYCLES; on expiry tx_error and tx_flag_clr pulse,
//                 the rest of the word is dropped and no word_done is given.
//     undefined - the scheduler waits for tx_done indefinitely and
//                 tx_error is tied low.
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int UART_Nbit      = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                clk,
  input logic                reset,
  uart_tx_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_DONE,
    S_CLEAR,
    S_GAP
  } state_t;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                state;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [1:0]            count;
  logic [1:0]            byte_idx;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  rr_last;

  logic [UART_Nbit-1:0]  tx_data_q;
  logic                  tx_load_q;
  logic                  tx_start_q;
  logic                  tx_flag_clr_q;
  logic                  busy_q;
  logic                  grant_id_q;
  logic                  word_done_q;
  logic                  tx_error_q;

  logic                  grant0;
  logic                  grant1;
  logic                  idle_accept;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [1:0]            sel_nbytes;

`ifdef UART_TX_TIMEOUT_EN
  localparam logic [12:0] WD_LAST = 13'(TIMEOUT_CYCLES - 1);
  logic [12:0] wd_cnt;
`endif

  // Round-robin arbitration: a lone requester always wins; on a tie the port
  // that did not win last time goes first.
  // NOTE: every signal gets a default before any branch so this block stays
  // purely combinational and infers no latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0 = rr_last;
      grant1 = ~rr_last;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end

  // Readies are only offered from IDLE and are suppressed while reset is held
  // so that no output is high during reset.
  assign idle_accept    = (state == S_IDLE) && !reset;
  assign bus.req0_ready = idle_accept && grant0;
  assign bus.req1_ready = idle_accept && grant1;

  assign sel_data   = grant1 ? bus.req1_data   : bus.req0_data;
  assign sel_nbytes = grant1 ? bus.req1_nbytes : bus.req0_nbytes;
  assign shift_nxt  = shift >> UART_Nbit;

  // Single FSM process; every output is a register written on the transition
  // into the state that owns it, so it is high exactly while in that state.
  // NOTE: state is updated with non-blocking assignments only, so every
  // branch sees the values from the start of the cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the word shift register is reset along with the control state;
      // it is small and a defined value keeps tx_data clean after reset.
      state         <= S_IDLE;
      shift         <= '0;
      count         <= '0;
      byte_idx      <= '0;
      gap_cnt       <= '0;
      rr_last       <= 1'b1;
      tx_data_q     <= '0;
      tx_load_q     <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_flag_clr_q <= 1'b0;
      busy_q        <= 1'b0;
      grant_id_q    <= 1'b0;
      word_done_q   <= 1'b0;
      tx_error_q    <= 1'b0;
`ifdef UART_TX_TIMEOUT_EN
      wd_cnt        <= '0;
`endif
    end else begin
      tx_load_q     <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_flag_clr_q <= 1'b0;
      word_done_q   <= 1'b0;
      tx_error_q    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant0 || grant1) begin
            shift      <= sel_data;
            count      <= sel_nbytes;
            byte_idx   <= '0;
            grant_id_q <= grant1;
            rr_last    <= grant1;
            tx_data_q  <= sel_data[UART_Nbit-1:0];
            tx_load_q  <= 1'b1;
            busy_q     <= 1'b1;
            state      <= S_LOAD;
          end
        end

        S_LOAD: begin
          tx_start_q <= 1'b1;
          state      <= S_START;
        end

        S_START: begin
`ifdef UART_TX_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (bus.tx_done) begin
            tx_flag_clr_q <= 1'b1;
            word_done_q   <= (byte_idx == count);
            state         <= S_CLEAR;
          end
`ifdef UART_TX_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            // Abandon the word; rr_last already names the aborted port.
            tx_error_q    <= 1'b1;
            tx_flag_clr_q <= 1'b1;
            busy_q        <= 1'b0;
            state         <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 13'd1;
          end
`endif
        end

        S_CLEAR: begin
          shift    <= shift_nxt;
          byte_idx <= byte_idx + 2'd1;
          // Compare before the increment so count = 3 sends four bytes
          // without byte_idx wrapping.
          if (byte_idx == count) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else if (GAP_CYCLES == 0) begin
            tx_data_q <= shift_nxt[UART_Nbit-1:0];
            tx_load_q <= 1'b1;
            state     <= S_LOAD;
          end else begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            tx_data_q <= shift[UART_Nbit-1:0];
            tx_load_q <= 1'b1;
            state     <= S_LOAD;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.tx_load     = tx_load_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_flag_clr = tx_flag_clr_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.word_done   = word_done_q;
`ifdef UART_TX_TIMEOUT_EN
  assign bus.tx_error    = tx_error_q;
`else
  assign bus.tx_error    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//   Self-checking bench for uart_tx_scheduler. Requesters are modelled as
//   per-port word queues, the transmitter as a buffer plus a done-flag timer.
//   Every accepted word is expanded into its expected byte stream; every
//   transmitted byte, grant, gap length and word_done is compared against it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

  localparam int GAP = 2;
  localparam int TO  = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  nb;
  } req_t;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic       port;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_scheduler_if bus ();

  uart_tx_scheduler #(
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_clr_cyc = 0;
  int   done_timer = 0;
  int   n_start = 0;
  int   n_wd = 0;
  int   n_acc = 0;
  bit   present0, present1;
  bit   acc_valid, acc_port;
  bit   rr_model = 1'b1;
  bit   prev_load, last_was_last;
  bit   rand_mode = 1'b0;
  bit   done_en = 1'b1;
  bit   saw_err = 1'b0;
  logic [7:0] tx_buf;
  req_t q0[$];
  req_t q1[$];
  exp_t exp_q[$];
  logic [7:0] obs_bytes[$];
  bit   acc_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input logic [31:0] d, input logic [1:0] nb);
    req_t r;
    r.data = d;
    r.nb   = nb;
    return r;
  endfunction

  task automatic drive_inputs();
    bus.req0_valid  = present0;
    bus.req0_data   = present0 ? q0[0].data : 32'h0;
    bus.req0_nbytes = present0 ? q0[0].nb   : 2'd0;
    bus.req1_valid  = present1;
    bus.req1_data   = present1 ? q1[0].data : 32'h0;
    bus.req1_nbytes = present1 ? q1[0].nb   : 2'd0;
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    exp_q.delete();
    present0      = 1'b0;
    present1      = 1'b0;
    acc_valid     = 1'b0;
    rr_model      = 1'b1;
    prev_load     = 1'b0;
    last_was_last = 1'b0;
    done_timer    = 0;
    bus.tx_done   = 1'b0;
    drive_inputs();
  endtask

  // One clock of the environment: observe registered outputs at the falling
  // edge, run the transmitter and requester models, then sample the readies.
  task automatic tick();
    req_t r;
    exp_t e;
    bit   exp_p;
    @(negedge clk);
    cyc++;

    // An accept sampled last cycle took effect at the edge just passed.
    if (acc_valid) begin
      if (acc_port) begin r = q1.pop_front(); present1 = 1'b0; end
      else          begin r = q0.pop_front(); present0 = 1'b0; end
      for (int i = 0; i <= int'(r.nb); i++) begin
        e.b    = r.data[8*i +: 8];
        e.last = (i == int'(r.nb));
        e.port = acc_port;
        exp_q.push_back(e);
      end
      acc_log.push_back(acc_port);
      rr_model = acc_port;
      n_acc++;
      check("grant_id", 32'(bus.grant_id), 32'(acc_port));
      check("load_latency", 32'(bus.tx_load), 32'd1);
      acc_valid = 1'b0;
    end else if (bus.tx_load) begin
      check("gap_len", 32'(cyc - last_clr_cyc), 32'(GAP + 1));
    end

    if (bus.tx_load) tx_buf = bus.tx_data;

    if (done_timer > 0) begin
      done_timer--;
      if (done_timer == 0 && done_en) bus.tx_done = 1'b1;
    end

    if (bus.tx_start) begin
      n_start++;
      check("start_after_load", 32'(prev_load), 32'd1);
      check("byte_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tx_byte", 32'(tx_buf), 32'(e.b));
        check("byte_port", 32'(bus.grant_id), 32'(e.port));
        last_was_last = e.last;
      end
      obs_bytes.push_back(tx_buf);
      done_timer = rand_mode ? int'($urandom_range(1, 12)) : 10;
    end

    if (bus.tx_flag_clr) begin
      check("word_done_flag", 32'(bus.word_done), 32'(last_was_last));
      bus.tx_done  = 1'b0;
      last_clr_cyc = cyc;
    end
    if (bus.word_done) n_wd++;
    if (bus.tx_error) saw_err = 1'b1;
    prev_load = bus.tx_load;

    if (!present0 && q0.size() != 0 && (!rand_mode || $urandom_range(0, 3) == 0)) present0 = 1'b1;
    if (!present1 && q1.size() != 0 && (!rand_mode || $urandom_range(0, 3) == 0)) present1 = 1'b1;
    drive_inputs();
    #1;

    if (present0 && present1)
      check("one_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
    if (bus.busy && (present0 || present1))
      check("ready_held", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
    if (bus.req0_ready || bus.req1_ready) begin
      exp_p = (present0 && present1) ? ~rr_model : present1;
      check("arb_winner", 32'(bus.req1_ready), 32'(exp_p));
      acc_port  = bus.req1_ready;
      acc_valid = 1'b1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_idle(input int budget);
    int k;
    bit drained;
    k = 0;
    do begin
      tick();
      k++;
      drained = (q0.size() == 0) && (q1.size() == 0) && !present0 && !present1 &&
                !acc_valid && !bus.busy && (exp_q.size() == 0);
    end while (!drained && k < budget);
    check("drain_within_budget", 32'(drained), 32'd1);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k;
    k = 0;
    while (n_start < target && k < budget) begin
      tick();
      k++;
    end
    check("start_within_budget", 32'(n_start >= target), 32'd1);
  endtask

  initial begin
    int   base, wd0, acc0;
    logic [7:0] ref_bytes [4];

    bus.tx_done = 1'b0;
    clear_model();

    // Reset state.
    apply_reset();
    tick();
    check("reset_ctrl", 32'({bus.busy, bus.tx_load, bus.tx_start, bus.tx_flag_clr,
                             bus.word_done, bus.tx_error, bus.grant_id,
                             bus.req0_ready, bus.req1_ready}), 32'd0);
    check("reset_tx_data", 32'(bus.tx_data), 32'd0);

    // Four-byte word on port 0.
    obs_bytes.delete();
    wd0  = n_wd;
    base = n_start;
    q0.push_back(mk(32'h12345678, 2'd3));
    run_idle(200);
    ref_bytes[0] = 8'h78; ref_bytes[1] = 8'h56; ref_bytes[2] = 8'h34; ref_bytes[3] = 8'h12;
    check("w4_starts", 32'(n_start - base), 32'd4);
    for (int i = 0; i < 4; i++)
      check("w4_byte", 32'(obs_bytes.size() > i ? obs_bytes[i] : 8'h00), 32'(ref_bytes[i]));
    check("w4_word_done", 32'(n_wd - wd0), 32'd1);
    check("w4_busy_after", 32'(bus.busy), 32'd0);

    // Simultaneous requests after reset: port 0, then port 1, then port 0 again.
    apply_reset();
    acc_log.delete();
    q0.push_back(mk(32'h000000AA, 2'd0));
    q1.push_back(mk(32'h000000BB, 2'd0));
    run_idle(200);
    check("tie1_first", 32'(acc_log.size() > 0 ? acc_log[0] : 1'b1), 32'd0);
    check("tie1_second", 32'(acc_log.size() > 1 ? acc_log[1] : 1'b0), 32'd1);
    acc_log.delete();
    q0.push_back(mk(32'h000000AA, 2'd0));
    q1.push_back(mk(32'h000000BB, 2'd0));
    run_idle(200);
    check("tie2_first", 32'(acc_log.size() > 0 ? acc_log[0] : 1'b1), 32'd0);

    // Single-byte word.
    obs_bytes.delete();
    wd0 = n_wd;
    q0.push_back(mk(32'hDEADBEEF, 2'd0));
    run_idle(200);
    check("w1_count", 32'(obs_bytes.size()), 32'd1);
    check("w1_byte", 32'(obs_bytes.size() > 0 ? obs_bytes[0] : 8'h00), 32'hEF);
    check("w1_word_done", 32'(n_wd - wd0), 32'd1);

    // Port 1 requests while port 0's first byte waits for done.
    acc_log.delete();
    q0.push_back(mk(32'hCAFEF00D, 2'd1));
    wait_starts(n_start + 1, 50);
    repeat (2) tick();
    q1.push_back(mk(32'h13579BDF, 2'd2));
    run_idle(300);
    check("holdoff_order0", 32'(acc_log.size() > 0 ? acc_log[0] : 1'b1), 32'd0);
    check("holdoff_order1", 32'(acc_log.size() > 1 ? acc_log[1] : 1'b0), 32'd1);

    // Reset during the second byte's wait for done.
    q0.push_back(mk(32'h0BADCAFE, 2'd3));
    wait_starts(n_start + 2, 100);
    repeat (2) tick();
    reset = 1'b1;
    #1;
    check("midreset_ctrl", 32'({bus.busy, bus.tx_load, bus.tx_start, bus.tx_flag_clr,
                                bus.word_done, bus.tx_error, bus.grant_id,
                                bus.req0_ready, bus.req1_ready}), 32'd0);
    check("midreset_tx_data", 32'(bus.tx_data), 32'd0);
    clear_model();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base = n_start;
    repeat (30) tick();
    check("postreset_no_start", 32'(n_start - base), 32'd0);
    check("postreset_idle", 32'(bus.busy), 32'd0);

`ifdef UART_TX_TIMEOUT_EN
    // Done flag never arrives: watchdog aborts the word.
    begin
      int s, k;
      apply_reset();
      done_en = 1'b0;
      wd0 = n_wd;
      q0.push_back(mk(32'h11223344, 2'd1));
      wait_starts(n_start + 1, 50);
      s = cyc;
      k = 0;
      while (!bus.tx_error && k < 40) begin
        tick();
        k++;
      end
      check("timeout_latency", 32'(cyc - s), 32'(TO + 1));
      check("timeout_idle", 32'(bus.busy), 32'd0);
      check("timeout_no_word_done", 32'(n_wd - wd0), 32'd0);
      done_en = 1'b1;
      apply_reset();
    end
`endif

    // Randomised traffic on both ports with random done delays.
    apply_reset();
    rand_mode = 1'b1;
    wd0  = n_wd;
    acc0 = n_acc;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) q0.push_back(mk($urandom, 2'($urandom_range(0, 3))));
      else                           q1.push_back(mk($urandom, 2'($urandom_range(0, 3))));
    end
    run_idle(6000);
    check("rand_accepts", 32'(n_acc - acc0), 32'd40);
    check("rand_word_done", 32'(n_wd - wd0), 32'd40);
    check("rand_no_leftover", 32'(exp_q.size()), 32'd0);
`ifndef UART_TX_TIMEOUT_EN
    check("no_tx_error", 32'(saw_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no completion expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART byte transmitter between two 32-bit word requesters:
  - port 0: CPU memory-mapped store path.
  - port 1: debug/trace path.
- Round-robin arbitration between the two ports.
- Serializes each accepted word into 1–4 bytes, LSB byte first.
- Sequences the transmitter's load / start / done-flag / flag-clear handshake.
- Sits between the MIPS I/O decode and UART_controller's Tx side.

Parameters:
- DATA_WIDTH, 32, width of request words.
- UART_Nbit, 8, transmitter byte width; DATA_WIDTH/UART_Nbit = 4 bytes max per word.
- GAP_CYCLES, 2, idle cycles inserted between bytes of one word (0 = no gap).
- TIMEOUT_CYCLES, 4096, done-flag watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 has a word.
- req0_data  in  32  port 0 word.
- req0_nbytes  in  2  port 0 byte count minus one (0→1 byte … 3→4 bytes).
- req0_ready  out  1  port 0 word accepted this cycle when high with req0_valid.
- req1_valid  in  1  port 1 has a word.
- req1_data  in  32  port 1 word.
- req1_nbytes  in  2  port 1 byte count minus one.
- req1_ready  out  1  port 1 accept strobe.
- tx_data  out  8  byte to transmitter buffer.
- tx_load  out  1  store tx_data into transmitter buffer.
- tx_start  out  1  one-cycle start-transmission pulse.
- tx_done  in  1  transmitter done flag (level, held until cleared).
- tx_flag_clr  out  1  one-cycle active-high clear of tx_done.
- busy  out  1  high in any state except IDLE.
- grant_id  out  1  port owning the word in progress (holds last value in IDLE).
- word_done  out  1  one-cycle pulse after last byte's flag is cleared.
- tx_error  out  1  one-cycle timeout pulse (optional feature).

Behaviour:
- Reset: state=IDLE; all outputs 0; shift register, byte counter and gap counter 0; rr_last=1 so port 0 wins the first tie. Reset asserted mid-word aborts immediately; no tx_start is issued after reset releases until a new request arrives.
- Arbitration (combinational, IDLE only):
  - Only one valid → grant that port.
  - Both valid → grant the port != rr_last.
  - reqN_ready = (state==IDLE) & grantN. At most one ready is high per cycle.
- Accept (cycle N): latch data into shift register, count = nbytes, byte_idx=0, grant_id, rr_last=granted port. Next state LOAD.
- States; outputs are decoded from the state register:
  - LOAD (N+1): tx_data=shift[7:0] (registered, holds until next LOAD); tx_load=1. → START.
  - START (N+2): tx_start=1. → WAIT_DONE.
  - WAIT_DONE: wait for tx_done=1. → CLEAR.
  - CLEAR: tx_flag_clr=1; shift >>= 8; byte_idx++.
    - If byte_idx==count: word_done=1 this cycle, → IDLE.
    - Else if GAP_CYCLES==0 → LOAD.
    - Else → GAP.
  - GAP: count GAP_CYCLES cycles, → LOAD.
- Width rules: byte_idx is 2 bits; the comparison uses pre-increment byte_idx == count, so count=3 sends 4 bytes without wrap.
- Simultaneous events:
  - A new valid during a word is held off: ready stays 0 until IDLE.
  - tx_done high on entry to WAIT_DONE completes that cycle.
  - The flag is always cleared before the next LOAD, so no stale done is possible.
- Back-to-back: word_done cycle is followed by IDLE; the next accept is at the earliest in the cycle after word_done.

Optional Feature:
- UART_TX_TIMEOUT_EN defined:
  - A 13-bit watchdog counts cycles in WAIT_DONE.
  - On reaching TIMEOUT_CYCLES: tx_error=1 and tx_flag_clr=1 for one cycle, the remaining bytes are dropped, no word_done is issued, → IDLE. rr_last keeps the aborted port.
- Undefined: WAIT_DONE waits indefinitely; tx_error is tied 0; no counter logic.

Test Plan:
- Reset, then req0 word 0x12345678, nbytes=3, tx_done modelled 10 cycles after each tx_start:
  - tx_data sequence 0x78, 0x56, 0x34, 0x12.
  - 4 tx_start pulses, each byte followed by 2 GAP cycles.
  - One word_done; busy low afterward.
- Both ports valid at the same cycle after reset (req0=0xAA, req1=0xBB, nbytes=0):
  - Port 0 is served first, then port 1.
  - Repeat with both valid: port 0 again (rr_last=1 → port 0).
- nbytes=0 on 0xDEADBEEF → exactly one byte 0xEF, then word_done.
- req1 asserts valid during port 0's WAIT_DONE → req1_ready stays 0 until IDLE, then accepts; no byte is lost or duplicated.
- Assert reset while in WAIT_DONE of byte 2 → all outputs 0 within the same cycle; after release, no tx_start without a new request.
- With UART_TX_TIMEOUT_EN and TIMEOUT_CYCLES=16, tx_done held 0 → tx_error pulse 16 cycles after entering WAIT_DONE, return to IDLE, no word_done.
